// File: rtl/wb_uart_tx_pkg.sv
// Shared definitions for the Wishbone UART transmitter: register offsets,
// STATUS bit positions, TX state encoding and the bit-period helper.
package wb_uart_tx_pkg;

    // Register offsets as seen on wb_adr_i[3:2]
    localparam logic [1:0] REG_TXDATA  = 2'd0;
    localparam logic [1:0] REG_STATUS  = 2'd1;
    localparam logic [1:0] REG_DIVISOR = 2'd2;
    localparam logic [1:0] REG_IRQ_EN  = 2'd3;

    // STATUS register layout
    localparam int ST_FULL      = 0;
    localparam int ST_EMPTY     = 1;
    localparam int ST_BUSY      = 2;
    localparam int ST_OVERFLOW  = 3;
    localparam int ST_LEVEL_LSB = 8;
    localparam int LEVEL_W      = 9;

    // Shortest bit period the transmitter will run at
    localparam logic [15:0] MIN_BIT_PERIOD = 16'd2;

    // Transmit state machine encoding
    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_t;

    // Effective bit period in clock cycles for a given DIVISOR value
    function automatic logic [15:0] bit_period(input logic [15:0] div);
        return (div < MIN_BIT_PERIOD) ? MIN_BIT_PERIOD : div;
    endfunction

endpackage

// File: rtl/wb_uart_tx_fifo.sv
// Single-clock synchronous byte FIFO feeding the UART transmitter.
// Read data is show-ahead: rd_data always presents the oldest entry.
// A push while full is accepted only when a pop happens in the same cycle.
module uart_tx_fifo #(
    parameter int DEPTH = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic       pop,
    input  logic [7:0] wr_data,
    output logic [7:0] rd_data,
    output logic       full,
    output logic       empty,
    output logic [8:0] level
);

    localparam int         AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [8:0] DEPTH_LVL = 9'(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (level == DEPTH_LVL);
    assign empty   = (level == 9'd0);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign rd_data = mem[rd_ptr];

    // Storage array; contents are don't-care until written
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of two
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= 9'd0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   level <= level + 9'd1;
                2'b01:   level <= level - 9'd1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/wb_uart_tx.sv
// Wishbone-attached UART transmitter with a TX FIFO and programmable divisor.
// Registers: TXDATA (W), STATUS (R), DIVISOR (R/W), IRQ_EN (R/W).
// Optional interrupt support is built when WB_UART_TX_IRQ_EN is defined;
// otherwise irq_o is tied low and IRQ_EN reads as zero.
module wb_uart_tx
    import wb_uart_tx_pkg::*;
#(
    parameter int FIFO_DEPTH  = 16,
    parameter int DEFAULT_DIV = 868
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic [31:0] wb_adr_i,
    input  logic [31:0] wb_dat_i,
    input  logic [3:0]  wb_sel_i,
    input  logic        wb_we_i,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    input  logic [2:0]  wb_cti_i,
    input  logic [1:0]  wb_bte_i,
    output logic [31:0] wb_dat_o,
    output logic        wb_ack_o,
    output logic        wb_err_o,
    output logic        wb_rty_o,
    output logic        txd_o,
    output logic        irq_o
);

    // Bus decode
    logic [1:0]  reg_sel;
    logic        bus_req;
    logic        bus_acc;
    logic        tx_write;
    logic        status_rd;
    logic        div_write;
    logic [31:0] rd_mux;
    logic [31:0] status_word;

    // Register state
    logic [15:0] divisor;
    logic        overflow;
    logic        overflow_set;
    logic        irq_en;

    // FIFO interface
    logic [7:0]  fifo_rd_data;
    logic        fifo_full;
    logic        fifo_empty;
    logic [8:0]  fifo_level;
    logic        fifo_pop;

    // Transmitter
    tx_state_t   state;
    tx_state_t   next_state;
    logic [15:0] bit_cnt;
    logic [15:0] div_lat;
    logic [2:0]  bit_idx;
    logic [7:0]  shift_reg;
    logic        frame_load;
    logic        bit_reload;
    logic        bit_adv;
    logic        cnt_zero;
    logic        busy;

    logic        unused_bits;

    assign wb_err_o = 1'b0;
    assign wb_rty_o = 1'b0;

    assign reg_sel      = wb_adr_i[3:2];
    assign bus_req      = wb_cyc_i & wb_stb_i & ~wb_ack_o;
    assign bus_acc      = wb_cyc_i & wb_stb_i & wb_ack_o;
    assign tx_write     = bus_acc & wb_we_i & (reg_sel == REG_TXDATA) & wb_sel_i[0];
    assign status_rd    = bus_acc & ~wb_we_i & (reg_sel == REG_STATUS);
    assign div_write    = bus_acc & wb_we_i & (reg_sel == REG_DIVISOR);
    assign overflow_set = tx_write & fifo_full & ~fifo_pop;

    assign busy     = (state != TX_IDLE);
    assign cnt_zero = (bit_cnt == 16'd0);

    assign unused_bits = ^{wb_adr_i[31:4], wb_adr_i[1:0], wb_dat_i[31:16],
                           wb_sel_i[3:1], wb_cti_i, wb_bte_i};

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (wb_clk_i),
        .rst     (wb_rst_i),
        .push    (tx_write),
        .pop     (fifo_pop),
        .wr_data (wb_dat_i[7:0]),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (fifo_level)
    );

    // Assemble the STATUS word from live flags and FIFO occupancy
    always_comb begin
        status_word = '0;
        status_word[ST_LEVEL_LSB +: LEVEL_W] = fifo_level;
        status_word[ST_OVERFLOW] = overflow;
        status_word[ST_BUSY]     = busy;
        status_word[ST_EMPTY]    = fifo_empty;
        status_word[ST_FULL]     = fifo_full;
    end

    // Read data multiplexer; TXDATA is write-only and reads back zero
    always_comb begin
        rd_mux = '0;
        case (reg_sel)
            REG_STATUS:  rd_mux = status_word;
            REG_DIVISOR: rd_mux = {16'd0, divisor};
            REG_IRQ_EN:  rd_mux = {31'd0, irq_en};
            default:     rd_mux = '0;
        endcase
    end

    // Single-cycle registered acknowledge with read data captured alongside it
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            wb_ack_o <= 1'b0;
            wb_dat_o <= 32'd0;
        end else begin
            wb_ack_o <= bus_req;
            if (bus_req) begin
                wb_dat_o <= wb_we_i ? 32'd0 : rd_mux;
            end
        end
    end

    // DIVISOR register; only takes effect at the start of the next frame
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            divisor <= 16'(DEFAULT_DIV);
        end else if (div_write) begin
            divisor <= wb_dat_i[15:0];
        end
    end

    // Sticky overflow flag; a same-cycle overflow beats the read-to-clear
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            overflow <= 1'b0;
        end else if (overflow_set) begin
            overflow <= 1'b1;
        end else if (status_rd) begin
            overflow <= 1'b0;
        end
    end

`ifdef WB_UART_TX_IRQ_EN
    // IRQ enable register
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            irq_en <= 1'b0;
        end else if (bus_acc & wb_we_i & (reg_sel == REG_IRQ_EN)) begin
            irq_en <= wb_dat_i[0];
        end
    end

    // Registered "transmitter drained" interrupt
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            irq_o <= 1'b0;
        end else begin
            irq_o <= irq_en & fifo_empty & ~busy;
        end
    end
`else
    assign irq_en = 1'b0;
    assign irq_o  = 1'b0;
`endif

    // TX state register
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state <= TX_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // TX next-state logic and datapath controls
    always_comb begin
        next_state = state;
        fifo_pop   = 1'b0;
        frame_load = 1'b0;
        bit_reload = 1'b0;
        bit_adv    = 1'b0;
        case (state)
            TX_IDLE: begin
                if (!fifo_empty) begin
                    next_state = TX_START;
                    fifo_pop   = 1'b1;
                    frame_load = 1'b1;
                end
            end
            TX_START: begin
                if (cnt_zero) begin
                    next_state = TX_DATA;
                    bit_reload = 1'b1;
                end
            end
            TX_DATA: begin
                if (cnt_zero) begin
                    bit_reload = 1'b1;
                    bit_adv    = 1'b1;
                    if (bit_idx == 3'd7) begin
                        next_state = TX_STOP;
                    end
                end
            end
            TX_STOP: begin
                if (cnt_zero) begin
                    if (!fifo_empty) begin
                        next_state = TX_START;
                        fifo_pop   = 1'b1;
                        frame_load = 1'b1;
                    end else begin
                        next_state = TX_IDLE;
                    end
                end
            end
            default: next_state = TX_IDLE;
        endcase
    end

    // Bit timer, bit index and frame data; the divisor is latched per frame
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            bit_cnt   <= 16'd0;
            div_lat   <= 16'(DEFAULT_DIV);
            bit_idx   <= 3'd0;
            shift_reg <= 8'd0;
        end else begin
            if (frame_load) begin
                bit_cnt   <= bit_period(divisor) - 16'd1;
                div_lat   <= divisor;
                shift_reg <= fifo_rd_data;
                bit_idx   <= 3'd0;
            end else begin
                if (bit_reload) begin
                    bit_cnt <= bit_period(div_lat) - 16'd1;
                end else if (!cnt_zero) begin
                    bit_cnt <= bit_cnt - 16'd1;
                end
                if (bit_adv) begin
                    bit_idx <= bit_idx + 3'd1;
                end
            end
        end
    end

    // Serial line: low for START, LSB-first data, high otherwise
    always_comb begin
        txd_o = 1'b1;
        case (state)
            TX_START: txd_o = 1'b0;
            TX_DATA:  txd_o = shift_reg[bit_idx];
            default:  txd_o = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_wb_uart_tx.sv
// Directed self-checking bench for wb_uart_tx (FIFO_DEPTH=16).
module tb_wb_uart_tx;

    localparam logic [31:0] ADR_TX  = 32'h0;
    localparam logic [31:0] ADR_ST  = 32'h4;
    localparam logic [31:0] ADR_DIV = 32'h8;
    localparam logic [31:0] ADR_IRQ = 32'hC;
    localparam logic [31:0] DIV_RESET = 32'd868;

`ifdef WB_UART_TX_IRQ_EN
    localparam logic IRQ_BUILD = 1'b1;
`else
    localparam logic IRQ_BUILD = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic [31:0] adr;
    logic [31:0] dat_w;
    logic [3:0]  sel;
    logic        we;
    logic        cyc;
    logic        stb;
    logic [2:0]  cti;
    logic [1:0]  bte;
    logic [31:0] dat_r;
    logic        ack;
    logic        err;
    logic        rty;
    logic        txd;
    logic        irq;

    int tests_run;
    int tests_failed;

    wb_uart_tx #(
        .FIFO_DEPTH  (16),
        .DEFAULT_DIV (868)
    ) dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .wb_adr_i (adr),
        .wb_dat_i (dat_w),
        .wb_sel_i (sel),
        .wb_we_i  (we),
        .wb_cyc_i (cyc),
        .wb_stb_i (stb),
        .wb_cti_i (cti),
        .wb_bte_i (bte),
        .wb_dat_o (dat_r),
        .wb_ack_o (ack),
        .wb_err_o (err),
        .wb_rty_o (rty),
        .txd_o    (txd),
        .irq_o    (irq)
    );

    // Free-running clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case something never completes
    initial begin
        #400000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // One Wishbone write; held through the ack cycle, then released
    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] d,
                                 input logic [3:0] s);
        int waited;
        @(negedge clk);
        adr = a; dat_w = d; sel = s; we = 1'b1; cyc = 1'b1; stb = 1'b1;
        waited = 0;
        @(posedge clk); #1;
        while (!ack && waited < 16) begin
            @(posedge clk); #1;
            waited++;
        end
        checkOutput("wr_ack", {31'd0, ack}, 32'd1);
        @(posedge clk); #1;
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        checkOutput("wr_ack_pulse", {31'd0, ack}, 32'd0);
    endtask

    // One Wishbone read
    task automatic busRead(input logic [31:0] a, output logic [31:0] d);
        int waited;
        @(negedge clk);
        adr = a; sel = 4'hF; we = 1'b0; cyc = 1'b1; stb = 1'b1;
        waited = 0;
        @(posedge clk); #1;
        while (!ack && waited < 16) begin
            @(posedge clk); #1;
            waited++;
        end
        checkOutput("rd_ack", {31'd0, ack}, 32'd1);
        d = dat_r;
        @(posedge clk); #1;
        cyc = 1'b0; stb = 1'b0;
        checkOutput("rd_ack_pulse", {31'd0, ack}, 32'd0);
    endtask

    task automatic readCheck(input string tag, input logic [31:0] a,
                             input logic [31:0] expected);
        logic [31:0] d;
        busRead(a, d);
        checkOutput(tag, d, expected);
    endtask

    // Wait for txd to go low, bounded by a cycle budget
    task automatic waitFrameStart(input int budget, output bit found, output int waited);
        found = 1'b0;
        waited = 0;
        while (!found && waited < budget) begin
            @(posedge clk); #1;
            waited++;
            if (txd == 1'b0) found = 1'b1;
        end
    endtask

    // Called in the first cycle of START; samples each of the 10 bits mid-bit
    task automatic sampleFrame(input int period, output logic [9:0] frame);
        repeat (period / 2) begin
            @(posedge clk); #1;
        end
        frame[0] = txd;
        for (int k = 1; k < 10; k++) begin
            repeat (period) begin
                @(posedge clk); #1;
            end
            frame[k] = txd;
        end
    endtask

    function automatic logic [31:0] expFrame(input logic [7:0] b);
        return {22'd0, 1'b1, b, 1'b0};
    endfunction

    initial begin
        logic [9:0] frame;
        bit         found;
        int         waited;

        tests_run = 0;
        tests_failed = 0;
        rst = 1'b1;
        adr = '0; dat_w = '0; sel = '0; we = 1'b0; cyc = 1'b0; stb = 1'b0;
        cti = '0; bte = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_txd", {31'd0, txd}, 32'd1);
        checkOutput("rst_ack", {31'd0, ack}, 32'd0);
        checkOutput("rst_dat", dat_r, 32'd0);
        checkOutput("rst_irq", {31'd0, irq}, 32'd0);
        checkOutput("rst_err", {31'd0, err}, 32'd0);
        checkOutput("rst_rty", {31'd0, rty}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        readCheck("rst_status", ADR_ST, 32'h2);
        readCheck("rst_divisor", ADR_DIV, DIV_RESET);
        readCheck("rst_irq_en", ADR_IRQ, 32'd0);
        readCheck("txdata_read", ADR_TX, 32'd0);

        // DIVISOR keeps only [15:0]
        applyStimulus(ADR_DIV, 32'hABCD_0004, 4'hF);
        readCheck("div_readback", ADR_DIV, 32'h4);

        // 0xA5 at 4 cycles per bit, 2-cycle first-bit latency, 40-cycle frame
        applyStimulus(ADR_TX, 32'hA5, 4'b0001);
        checkOutput("lat_hold", {31'd0, txd}, 32'd1);
        @(posedge clk); #1;
        checkOutput("lat_fall", {31'd0, txd}, 32'd0);
        sampleFrame(4, frame);
        checkOutput("frame_a5", {22'd0, frame}, expFrame(8'hA5));
        readCheck("busy_cycle38", ADR_ST, 32'h6);
        readCheck("idle_cycle40", ADR_ST, 32'h2);

        // Write with sel[0]=0 is acked but not queued
        applyStimulus(ADR_TX, 32'h77, 4'b1110);
        readCheck("sel_level", ADR_ST, 32'h2);
        waitFrameStart(60, found, waited);
        checkOutput("sel_no_frame", {31'd0, found}, 32'd0);

        // DIVISOR=0 runs at 2 cycles per bit; a mid-frame change affects the next frame
        applyStimulus(ADR_DIV, 32'd0, 4'hF);
        readCheck("div_zero", ADR_DIV, 32'd0);
        applyStimulus(ADR_TX, 32'h55, 4'b0001);
        fork
            begin : rx_thread
                logic [9:0] f;
                bit         fnd;
                int         w;
                waitFrameStart(20, fnd, w);
                checkOutput("div2_start", {31'd0, fnd}, 32'd1);
                sampleFrame(2, f);
                checkOutput("frame_div2", {22'd0, f}, expFrame(8'h55));
                waitFrameStart(20, fnd, w);
                checkOutput("div8_start", {31'd0, fnd}, 32'd1);
                checkOutput("div2_gap", w, 32'd1);
                sampleFrame(8, f);
                checkOutput("frame_div8", {22'd0, f}, expFrame(8'hC3));
            end
            begin : bus_thread
                applyStimulus(ADR_TX, 32'hC3, 4'b0001);
                applyStimulus(ADR_DIV, 32'd8, 4'hF);
            end
        join
        repeat (10) @(posedge clk);
        #1;
        readCheck("div_test_idle", ADR_ST, 32'h2);

        // Fill the FIFO behind an in-flight frame: 17 writes, the last is dropped
        applyStimulus(ADR_DIV, 32'd10, 4'hF);
        applyStimulus(ADR_TX, 32'hFF, 4'b0001);
        for (int i = 0; i < 17; i++) begin
            applyStimulus(ADR_TX, (i == 16) ? 32'hEE : i, 4'b0001);
        end
        readCheck("ovf_status", ADR_ST, 32'h100D);
        readCheck("ovf_cleared", ADR_ST, 32'h1005);
        for (int i = 0; i < 16; i++) begin
            waitFrameStart(120, found, waited);
            checkOutput("fifo_start", {31'd0, found}, 32'd1);
            if (i > 0) checkOutput("fifo_gap", waited, 32'd5);
            sampleFrame(10, frame);
            checkOutput("fifo_frame", {22'd0, frame}, expFrame(i[7:0]));
        end
        waitFrameStart(200, found, waited);
        checkOutput("no_dropped_frame", {31'd0, found}, 32'd0);
        readCheck("fifo_drained", ADR_ST, 32'h2);

        // Reset in the middle of DATA
        applyStimulus(ADR_DIV, 32'd4, 4'hF);
        applyStimulus(ADR_TX, 32'h00, 4'b0001);
        applyStimulus(ADR_TX, 32'h00, 4'b0001);
        repeat (8) begin
            @(posedge clk); #1;
        end
        checkOutput("pre_reset_data", {31'd0, txd}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("reset_txd", {31'd0, txd}, 32'd1);
        checkOutput("reset_ack", {31'd0, ack}, 32'd0);
        checkOutput("reset_dat", dat_r, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        readCheck("reset_status", ADR_ST, 32'h2);
        readCheck("reset_divisor", ADR_DIV, DIV_RESET);
        waitFrameStart(100, found, waited);
        checkOutput("reset_no_frame", {31'd0, found}, 32'd0);

        // Interrupt: low while busy, high one cycle after the last STOP
        applyStimulus(ADR_DIV, 32'd2, 4'hF);
        applyStimulus(ADR_IRQ, 32'd1, 4'hF);
        readCheck("irq_en_read", ADR_IRQ, {31'd0, IRQ_BUILD});
        checkOutput("irq_idle", {31'd0, irq}, {31'd0, IRQ_BUILD});
        applyStimulus(ADR_TX, 32'h81, 4'b0001);
        fork
            begin : irq_rx_thread
                logic [9:0] f;
                bit         fnd;
                int         w;
                waitFrameStart(20, fnd, w);
                checkOutput("irq_f1_start", {31'd0, fnd}, 32'd1);
                sampleFrame(2, f);
                checkOutput("irq_frame1", {22'd0, f}, expFrame(8'h81));
                checkOutput("irq_busy1", {31'd0, irq}, 32'd0);
                waitFrameStart(20, fnd, w);
                checkOutput("irq_f2_start", {31'd0, fnd}, 32'd1);
                sampleFrame(2, f);
                checkOutput("irq_frame2", {22'd0, f}, expFrame(8'h3C));
                checkOutput("irq_busy2", {31'd0, irq}, 32'd0);
                @(posedge clk); #1;
                checkOutput("irq_stop_end", {31'd0, irq}, 32'd0);
                @(posedge clk); #1;
                checkOutput("irq_after", {31'd0, irq}, {31'd0, IRQ_BUILD});
            end
            begin : irq_bus_thread
                applyStimulus(ADR_TX, 32'h3C, 4'b0001);
            end
        join

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
